// File: rtl/noc_flit_pkg.sv
// Shared flit-format definitions for the NoC transmit and (future) receive endpoints.
// Field positions are derived from flit width and VC/address widths so both ends agree.
package noc_flit_pkg;

  // Widest flit make_flit can build; callers size-cast the result to their WIDTH.
  localparam int MAX_FLIT_W = 512;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int vc_bits(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int valid_pos(input int width);
    return width - 1;
  endfunction

  function automatic int head_pos(input int width);
    return width - 2;
  endfunction

  function automatic int tail_pos(input int width);
    return width - 3;
  endfunction

  function automatic int vc_msb(input int width);
    return width - 4;
  endfunction

  function automatic int dest_msb(input int width, input int vc_w);
    return width - 4 - vc_w;
  endfunction

  function automatic int payload_w(input int width, input int vc_w, input int addr_w);
    return width - 3 - vc_w - addr_w;
  endfunction

  // vc, dest and payload must already fit their fields (zero-extended by the caller).
  function automatic logic [MAX_FLIT_W-1:0] make_flit(
    input int                    width,
    input int                    vc_w,
    input int                    addr_w,
    input logic                  head,
    input logic                  tail,
    input logic [31:0]           vc,
    input logic [31:0]           dest,
    input logic [MAX_FLIT_W-1:0] payload
  );
    logic [MAX_FLIT_W-1:0] f;
    f = payload;
    f = f | (MAX_FLIT_W'(dest) << payload_w(width, vc_w, addr_w));
    f = f | (MAX_FLIT_W'(vc) << (vc_msb(width) - vc_w + 1));
    f = f | (MAX_FLIT_W'(tail) << tail_pos(width));
    f = f | (MAX_FLIT_W'(head) << head_pos(width));
    f = f | (MAX_FLIT_W'(1'b1) << valid_pos(width));
    return f;
  endfunction

endpackage

// File: rtl/noc_flit_tx_credit.sv
// Per-VC credit counter: starts at VC_DEPTH, saturates there and flags an overflow pulse.
module noc_credit_counter #(
  parameter int VC_DEPTH = 8,
  parameter int CNT_W    = $clog2(VC_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d  = count_q;
    overflow = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (count_q == CNT_W'(VC_DEPTH)) overflow = 1'b1;
        else                             count_d  = count_q + CNT_W'(1);
      end
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (reset) count_q <= CNT_W'(VC_DEPTH);
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/noc_flit_tx.sv
// NoC packet transmitter: segments packets into head/body/tail flits under per-VC credit flow control.
// Optional NOC_TX_STATS_EN adds 32-bit packet, flit and stall counters.
module noc_flit_tx
  import noc_flit_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int N         = 16,
  parameter int NUM_VC    = 2,
  parameter int VC_DEPTH  = 8,
  parameter int MAX_FLITS = 4,
  localparam int ADDR_W    = addr_bits(N),
  localparam int VC_W      = vc_bits(NUM_VC),
  localparam int LEN_W     = $clog2(MAX_FLITS + 1),
  localparam int PAYLOAD_W = payload_w(WIDTH, VC_W, ADDR_W)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pkt_valid,
  output logic                           pkt_ready,
  input  logic [ADDR_W-1:0]              pkt_dest,
  input  logic [VC_W-1:0]                pkt_vc,
  input  logic [LEN_W-1:0]               pkt_len,
  input  logic [MAX_FLITS*PAYLOAD_W-1:0] pkt_data,
  output logic [WIDTH-1:0]               flit_out,
  input  logic [NUM_VC-1:0]              credit_in,
  output logic                           credit_err,
  output logic                           busy
`ifdef NOC_TX_STATS_EN
  ,
  output logic [31:0]                    pkt_sent_cnt,
  output logic [31:0]                    flit_sent_cnt,
  output logic [31:0]                    stall_cnt
`endif
);

  localparam int CNT_W = $clog2(VC_DEPTH + 1);
  localparam int IDX_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

  state_t                                 state_q, state_d;
  logic [ADDR_W-1:0]                      dest_q, dest_d;
  logic [VC_W-1:0]                        vc_q, vc_d;
  logic [LEN_W-1:0]                       len_q, len_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [MAX_FLITS-1:0][PAYLOAD_W-1:0]    data_q, data_d;
  logic [WIDTH-1:0]                       flit_q, flit_d;
  logic                                   credit_err_q, credit_err_d;

  logic [NUM_VC-1:0][CNT_W-1:0]           cnt;
  logic [NUM_VC-1:0]                      dec;
  logic [NUM_VC-1:0]                      ovf;
  logic [LEN_W-1:0]                       len_norm;
  logic                                   can_send;
  logic                                   is_head;
  logic                                   is_tail;

  // Registered count only: a credit arriving this cycle cannot enable a send this cycle.
  assign can_send = (cnt[vc_q] != '0);
  assign is_head  = (idx_q == '0);
  assign is_tail  = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  always_comb begin
    len_norm = pkt_len;
    if (pkt_len == '0)                         len_norm = LEN_W'(1);
    else if (pkt_len > LEN_W'(MAX_FLITS))      len_norm = LEN_W'(MAX_FLITS);
  end

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    vc_d         = vc_q;
    len_d        = len_q;
    idx_d        = idx_q;
    data_d       = data_q;
    flit_d       = '0;
    dec          = '0;
    credit_err_d = credit_err_q | (|ovf);
    unique case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          dest_d  = pkt_dest;
          vc_d    = pkt_vc;
          len_d   = len_norm;
          data_d  = pkt_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (can_send) begin
          flit_d = WIDTH'(make_flit(WIDTH, VC_W, ADDR_W, is_head, is_tail,
                                    32'(vc_q), 32'(dest_q),
                                    MAX_FLIT_W'(data_q[idx_q])));
          dec    = NUM_VC'(1) << vc_q;
          idx_d  = idx_q + IDX_W'(1);
          if (is_tail) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      vc_q         <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      flit_q       <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      vc_q         <= vc_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      flit_q       <= flit_d;
      credit_err_q <= credit_err_d;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
    noc_credit_counter #(
      .VC_DEPTH (VC_DEPTH),
      .CNT_W    (CNT_W)
    ) u_credit (
      .clk      (clk),
      .reset    (reset),
      .dec      (dec[v]),
      .inc      (credit_in[v]),
      .count    (cnt[v]),
      .overflow (ovf[v])
    );
  end

  assign pkt_ready  = (state_q == IDLE);
  assign busy       = (state_q == SEND);
  assign flit_out   = flit_q;
  assign credit_err = credit_err_q;

`ifdef NOC_TX_STATS_EN
  logic [31:0] pkt_sent_q, flit_sent_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_sent_q  <= '0;
      flit_sent_q <= '0;
      stall_q     <= '0;
    end else begin
      if (busy && can_send)            flit_sent_q <= flit_sent_q + 32'd1;
      if (busy && can_send && is_tail) pkt_sent_q  <= pkt_sent_q + 32'd1;
      if (busy && !can_send)           stall_q     <= stall_q + 32'd1;
    end
  end

  assign pkt_sent_cnt  = pkt_sent_q;
  assign flit_sent_cnt = flit_sent_q;
  assign stall_cnt     = stall_q;
`endif

endmodule

// File: tb/tb_noc_flit_tx.sv
// Directed self-checking bench for noc_flit_tx at default parameters (128-bit flits, 2 VCs, depth 8).
module tb_noc_flit_tx;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pkt_valid = 1'b0;
  logic         pkt_ready;
  logic [3:0]   pkt_dest = '0;
  logic         pkt_vc = 1'b0;
  logic [2:0]   pkt_len = '0;
  logic [479:0] pkt_data = '0;
  logic [127:0] flit_out;
  logic [1:0]   credit_in = '0;
  logic         credit_err;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int flit_cnt = 0;

  noc_flit_tx dut (
    .clk        (clk),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dest   (pkt_dest),
    .pkt_vc     (pkt_vc),
    .pkt_len    (pkt_len),
    .pkt_data   (pkt_data),
    .flit_out   (flit_out),
    .credit_in  (credit_in),
    .credit_err (credit_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Counts every valid flit on the lane, sampled mid-cycle.
  always @(negedge clk) if (flit_out[127]) flit_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic h, input logic t, input logic v,
                                      input logic [3:0] d, input logic [119:0] p);
    return {1'b1, h, t, v, d, p};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Waits (bounded) for pkt_ready, then offers the packet for exactly one accepting edge.
  task automatic send_pkt(input logic [3:0] d, input logic v, input logic [2:0] l,
                          input logic [479:0] data);
    int w = 0;
    while (!pkt_ready && w < 200) begin
      tick();
      w++;
    end
    check("ready_wait", pkt_ready, 1'b1);
    pkt_valid = 1'b1;
    pkt_dest  = d;
    pkt_vc    = v;
    pkt_len   = l;
    pkt_data  = data;
    tick();
    pkt_valid = 1'b0;
  endtask

  initial begin
    int base;
    int low;

    // Reset state
    tick();
    do_reset();
    check("rst_flit",  flit_out,   128'h0);
    check("rst_ready", pkt_ready,  1'b1);
    check("rst_busy",  busy,       1'b0);
    check("rst_err",   credit_err, 1'b0);
    check("rst_cnt0",  dut.cnt[0], 4'd8);
    check("rst_cnt1",  dut.cnt[1], 4'd8);

    // Single-flit packet: head and tail together
    send_pkt(4'd5, 1'b1, 3'd1, 480'hABC);
    check("t1_busy",  busy,      1'b1);
    check("t1_ready", pkt_ready, 1'b0);
    tick();
    check("t1_flit",  flit_out,  mk(1'b1, 1'b1, 1'b1, 4'd5, 120'hABC));
    check("t1_top3",  flit_out[127:125], 3'b111);
    check("t1_ready_back", pkt_ready, 1'b1);
    check("t1_cnt1",  dut.cnt[1], 4'd7);
    tick();
    check("t1_idle_flit", flit_out, 128'h0);

    // Four-flit packet on vc0
    send_pkt(4'd3, 1'b0, 3'd4, {120'd4, 120'd3, 120'd2, 120'd1});
    low = pkt_ready ? 0 : 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_flit%0d", k), flit_out,
            mk(k == 0, k == 3, 1'b0, 4'd3, 120'(k + 1)));
      if (!pkt_ready) low++;
    end
    check("t2_ready_low_cycles", 128'(low), 128'd4);
    check("t2_cnt0", dut.cnt[0], 4'd4);
    tick();
    check("t2_idle_flit", flit_out, 128'h0);

    // Credit exhaustion over three packets, then a single credit releases one flit
    do_reset();
    base = flit_cnt;
    send_pkt(4'd7, 1'b0, 3'd4, {120'h4, 120'h3, 120'h2, 120'h1});
    send_pkt(4'd7, 1'b0, 3'd4, {120'h8, 120'h7, 120'h6, 120'h5});
    send_pkt(4'd7, 1'b0, 3'd4, {120'h13, 120'h12, 120'h11, 120'h10});
    tick(); tick(); tick();
    check("t3_flits_before_stall", 128'(flit_cnt - base), 128'd8);
    check("t3_stall_flit", flit_out, 128'h0);
    check("t3_stall_busy", busy, 1'b1);
    check("t3_cnt0_zero", dut.cnt[0], 4'd0);
    credit_in = 2'b01;
    tick();
    credit_in = 2'b00;
    check("t3_cnt0_one", dut.cnt[0], 4'd1);
    check("t3_no_bypass", flit_out, 128'h0);
    tick();
    check("t3_release_flit", flit_out, mk(1'b1, 1'b0, 1'b0, 4'd7, 120'h10));
    check("t3_cnt0_used", dut.cnt[0], 4'd0);
    tick();
    check("t3_stall_again", flit_out, 128'h0);

    // Credit return in the same cycle as a send leaves the count unchanged
    credit_in = 2'b01;
    tick();
    check("t4_cnt_before", dut.cnt[0], 4'd1);
    tick();
    credit_in = 2'b00;
    check("t4_flit_a", flit_out, mk(1'b0, 1'b0, 1'b0, 4'd7, 120'h11));
    check("t4_cnt_held", dut.cnt[0], 4'd1);
    tick();
    check("t4_flit_b_no_stall", flit_out, mk(1'b0, 1'b0, 1'b0, 4'd7, 120'h12));
    check("t4_cnt_after", dut.cnt[0], 4'd0);
    credit_in = 2'b01;
    tick();
    credit_in = 2'b00;
    tick();
    check("t4_tail", flit_out, mk(1'b0, 1'b1, 1'b0, 4'd7, 120'h13));
    check("t4_ready_at_tail", pkt_ready, 1'b1);

    // Credit overflow on an idle, full VC is sticky until reset
    credit_in = 2'b10;
    tick();
    credit_in = 2'b00;
    check("t5_err_set", credit_err, 1'b1);
    check("t5_cnt1_sat", dut.cnt[1], 4'd8);
    tick(); tick(); tick();
    check("t5_err_sticky", credit_err, 1'b1);
    do_reset();
    check("t5_err_cleared", credit_err, 1'b0);

    // Reset mid-packet abandons it without a tail
    send_pkt(4'd2, 1'b0, 3'd4, {120'h24, 120'h23, 120'h22, 120'h21});
    tick();
    check("t6_flit0", flit_out, mk(1'b1, 1'b0, 1'b0, 4'd2, 120'h21));
    tick();
    check("t6_flit1", flit_out, mk(1'b0, 1'b0, 1'b0, 4'd2, 120'h22));
    do_reset();
    check("t6_flit", flit_out, 128'h0);
    check("t6_ready", pkt_ready, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_cnt0", dut.cnt[0], 4'd8);
    check("t6_cnt1", dut.cnt[1], 4'd8);
    base = flit_cnt;
    tick(); tick(); tick(); tick();
    check("t6_no_tail", 128'(flit_cnt - base), 128'd0);

    // Length boundaries: 0 behaves as 1, 7 clamps to 4
    send_pkt(4'd9, 1'b1, 3'd0, 480'h55);
    tick();
    check("t7_len0_flit", flit_out, mk(1'b1, 1'b1, 1'b1, 4'd9, 120'h55));
    check("t7_len0_ready", pkt_ready, 1'b1);
    send_pkt(4'd4, 1'b1, 3'd7, {120'hd, 120'hc, 120'hb, 120'ha});
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t7_clamp_flit%0d", k), flit_out,
            mk(k == 0, k == 3, 1'b1, 4'd4, 120'(10 + k)));
    end
    check("t7_clamp_ready", pkt_ready, 1'b1);
    tick();
    check("t7_clamp_idle", flit_out, 128'h0);
    check("t7_cnt1", dut.cnt[1], 4'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_flit_tx.md
Name: noc_flit_tx

Overview:
- RTL-side NoC transmitter for one node; the sending end of the flit/credit interface into the booksim bridge.
- Accepts whole packets over a valid/ready port and segments them into head/body/tail flits.
- Drives the node's flit input lane and tracks per-VC credits returned by the NoC.
- Wormhole: a packet holds its assigned VC from head to tail.

Parameters:
- WIDTH, 128, flit width.
- N, 16, number of NoC nodes; ADDR_W = $clog2(N).
- NUM_VC, 2, VCs per port, must be >= 2; VC_W = $clog2(NUM_VC).
- VC_DEPTH, 8, downstream buffer depth per VC, equal to the initial credit count.
- MAX_FLITS, 4, maximum flits per packet; LEN_W = $clog2(MAX_FLITS+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  packet offered
- pkt_ready  out  1  packet accepted on a cycle where valid && ready
- pkt_dest  in  ADDR_W  destination node
- pkt_vc  in  VC_W  VC for the whole packet
- pkt_len  in  LEN_W  flit count
- pkt_data  in  MAX_FLITS*PAYLOAD_W  flit k payload = pkt_data[k*PAYLOAD_W +: PAYLOAD_W]
- flit_out  out  WIDTH  flit to the NoC lane; all-zero when idle
- credit_in  in  NUM_VC  one-cycle credit pulse per VC from the NoC
- credit_err  out  1  sticky credit-overflow flag
- busy  out  1  packet in flight

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Flit format:
  - bit WIDTH-1 valid, WIDTH-2 head, WIDTH-3 tail.
  - VC field [WIDTH-4 -: VC_W].
  - dest field [WIDTH-4-VC_W -: ADDR_W], replicated in every flit.
  - payload [PAYLOAD_W-1:0], where PAYLOAD_W = WIDTH-3-VC_W-ADDR_W (120 at defaults).
- Reset values: flit_out=0, pkt_ready=1, busy=0, credit_err=0, state IDLE, every credit counter = VC_DEPTH.
- FSM IDLE:
  - pkt_ready=1, flit_out<=0.
  - On valid&&ready, capture dest, vc, data and len into registers; set idx=0; go to SEND.
  - len 0 is treated as 1; len > MAX_FLITS is clamped to MAX_FLITS.
- FSM SEND:
  - pkt_ready=0, busy=1.
  - can_send = cnt[vc] != 0, using the registered count with no same-cycle bypass from credit_in.
  - If can_send: flit_out <= {1, idx==0, idx==len-1, vc, dest, payload[idx]}; cnt[vc]--; idx++; when idx==len-1 go to IDLE.
  - Else: flit_out <= 0 (stall).
- A single-flit packet sets head and tail in the same flit.
- Latency: accept at edge E0; first flit registered at E1 if credit is available; one flit per cycle thereafter.
- pkt_ready rises at the edge that registers the tail, so there is one bubble cycle between packets.
- Credit counters, width $clog2(VC_DEPTH+1), per VC:
  - send only: decrement.
  - credit_in only: increment.
  - both in the same cycle: unchanged.
  - increment at VC_DEPTH: counter holds at VC_DEPTH and credit_err sets, sticky until reset.
- Credits for all VCs are accepted in every state.
- Reset mid-packet: the partial packet is abandoned with no tail emitted; all state returns to reset values on the next edge. The NoC side is reset with it.

Optional Feature:
- Macro: NOC_TX_STATS_EN.
- When defined, adds outputs pkt_sent_cnt, flit_sent_cnt and stall_cnt, each 32 bits, wrapping.
  - pkt_sent_cnt increments on each tail sent.
  - flit_sent_cnt increments on each flit sent.
  - stall_cnt increments on each SEND cycle with can_send=0.
  - All three clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package noc_flit_pkg holds:
  - localparams and functions computing VALID/HEAD/TAIL/VC/DEST bit positions and PAYLOAD_W from WIDTH, N, NUM_VC.
  - function make_flit(head, tail, vc, dest, payload).
  - FSM state enum {IDLE, SEND}.
- The package is shared with the future receive endpoint.
- Sub-module noc_credit_counter: one instance per VC, with inputs dec and inc, outputs count and overflow, reset to VC_DEPTH.

Test Plan:
1. After reset, send dest=5, vc=1, len=1, data=0xABC.
   - One edge after accept: flit_out[127:125]=3'b111, VC field=1, dest field=5, payload=0xABC.
   - Next cycle flit_out=0; cnt[1]=7; pkt_ready back to 1.
2. Send len=4 on vc0 with payloads 1,2,3,4.
   - Four consecutive flits: head only, body, body, tail only, payloads in order.
   - pkt_ready low for exactly 4 cycles; cnt[0]=4.
3. Send three len-4 packets on vc0 with no credit_in.
   - 8 flits emitted, then flit_out=0 and stall.
   - One credit_in[0] pulse at cycle c: cnt goes to 1 at edge c, one flit at edge c+1, then stall again.
4. With cnt[0]=1 and a SEND in progress, pulse credit_in[0] in the cycle a flit is sent.
   - cnt stays 1 and the next flit goes out with no stall.
5. Idle with cnt[1]=8, pulse credit_in[1].
   - credit_err=1 next cycle and cnt[1]=8.
   - credit_err stays 1 until reset, then clears to 0.
6. Assert reset after flit 2 of a len-4 packet.
   - Next cycle: flit_out=0, pkt_ready=1, busy=0, all counters=8, no tail emitted.
